scalar_product_seq_ctrl: RTL and testbench

Sequencer that computes an unsigned scalar (dot) product of two packed `Ndata`-element vectors by time-multiplexing a single external `mul` instance, one element pair per clock. It sits between the vector source and the shared combinational multiplier. It accepts a vector pair on a valid/ready handshake, drives the multiplier operands and accumulates the products. It then presents the sum on a second valid/ready handshake.

---
 rtl/scalar_product_seq_ctrl.sv | 112 +++++++++++
 tb/tb_scalar_product_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_product_seq_ctrl.sv
// Dot-product sequencer: feeds one element pair per clock to a shared external
// multiplier, accumulates the products and returns the sum over valid/ready.
module scalar_product_seq_ctrl #(
  parameter  int Nbits = 4,
  parameter  int Ndata = 8,
  localparam int ACCW  = 2 * Nbits + $clog2(Ndata)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [Ndata*Nbits-1:0] A,
  input  logic [Ndata*Nbits-1:0] B,
  output logic [Nbits-1:0]       mul_multiplier,
  output logic [Nbits-1:0]       mul_multiplicand,
  input  logic [2*Nbits-1:0]     mul_product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACCW-1:0]        result,
  output logic                   busy
);

  localparam int IDXW = $clog2(Ndata);
  localparam logic [IDXW-1:0] LastIdx = IDXW'(Ndata - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [ACCW-1:0]        acc_q;
  logic [ACCW-1:0]        acc_d;
  logic [IDXW-1:0]        idx_q;
  logic [Ndata*Nbits-1:0] a_sr_q;
  logic [Ndata*Nbits-1:0] b_sr_q;
  logic [ACCW-1:0]        result_q;
  logic                   out_valid_q;
  logic                   busy_q;

  assign acc_d = acc_q + ACCW'(mul_product);

  // Operands come straight from the shift-register heads, but only while running.
  assign mul_multiplier   = (state_q == RUN) ? a_sr_q[Nbits-1:0] : '0;
  assign mul_multiplicand = (state_q == RUN) ? b_sr_q[Nbits-1:0] : '0;

  assign in_ready  = reset_n && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clear) begin
      // Abort wins over both handshakes; the last delivered result is kept.
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr_q  <= A;
            b_sr_q  <= B;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          a_sr_q <= a_sr_q >> Nbits;
          b_sr_q <= b_sr_q >> Nbits;
          idx_q  <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            result_q    <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_product_seq_ctrl.sv
// Bench for scalar_product_seq_ctrl: directed and random vectors checked
// against a plain-arithmetic dot-product model, with a model of the multiplier.
module tb_scalar_product_seq_ctrl;

  localparam int Nbits = 4;
  localparam int Ndata = 8;
  localparam int ACCW  = 11;
  localparam int VW    = Ndata * Nbits;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            clear = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [VW-1:0]   A = '0;
  logic [VW-1:0]   B = '0;
  logic [Nbits-1:0] mul_multiplier;
  logic [Nbits-1:0] mul_multiplicand;
  logic [2*Nbits-1:0] mul_product;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [ACCW-1:0] result;
  logic            busy;

  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] heldResult = '0;

  scalar_product_seq_ctrl #(.Nbits(Nbits), .Ndata(Ndata)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .clear            (clear),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .A                (A),
    .B                (B),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_product      (mul_product),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .busy             (busy)
  );

  // Stand-in for the shared combinational multiplier.
  assign mul_product = (2*Nbits)'(mul_multiplier) * (2*Nbits)'(mul_multiplicand);

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int dotRef(input logic [VW-1:0] a, input logic [VW-1:0] b);
    int s = 0;
    for (int i = 0; i < Ndata; i++)
      s += int'(a[i*Nbits +: Nbits]) * int'(b[i*Nbits +: Nbits]);
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called on the negedge right after the acceptance edge; ends on the first DONE negedge.
  task automatic finishRun(input logic [VW-1:0] a, input logic [VW-1:0] b, input bit checkOps);
    int expected = dotRef(a, b);
    for (int k = 0; k < Ndata; k++) begin
      if (checkOps) begin
        checkOutput($sformatf("opA_k%0d", k), 32'(mul_multiplier), 32'(a[k*Nbits +: Nbits]));
        checkOutput($sformatf("opB_k%0d", k), 32'(mul_multiplicand), 32'(b[k*Nbits +: Nbits]));
      end
      if (k == 0 || k == Ndata - 1) begin
        checkOutput($sformatf("run_busy_k%0d", k), 32'(busy), 1);
        checkOutput($sformatf("run_out_valid_k%0d", k), 32'(out_valid), 0);
        checkOutput($sformatf("run_in_ready_k%0d", k), 32'(in_ready), 0);
      end
      @(negedge clk);
    end
    checkOutput("done_out_valid", 32'(out_valid), 1);
    checkOutput("done_result", 32'(result), 32'(expected));
    checkOutput("done_busy", 32'(busy), 1);
    checkOutput("done_opA_zero", 32'(mul_multiplier), 0);
    heldResult = 32'(expected);
  endtask

  // Waits (bounded) for IDLE, offers the pair, then scrambles A/B after acceptance.
  task automatic applyStimulus(input logic [VW-1:0] a, input logic [VW-1:0] b, input bit checkOps);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_before_accept", 32'(in_ready), 1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    finishRun(a, b, checkOps);
  endtask

  task automatic consumeCheck();
    @(negedge clk);
    checkOutput("after_consume_out_valid", 32'(out_valid), 0);
    checkOutput("after_consume_in_ready", 32'(in_ready), 1);
    checkOutput("after_consume_busy", 32'(busy), 0);
    checkOutput("after_consume_result_held", 32'(result), heldResult);
  endtask

  initial begin
    logic [VW-1:0] ra;
    logic [VW-1:0] rb;

    // Reset values, both during and after a 10-cycle reset.
    repeat (10) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 0);
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_result", 32'(result), 0);
    checkOutput("reset_opA", 32'(mul_multiplier), 0);
    checkOutput("reset_opB", 32'(mul_multiplicand), 0);
    reset_n = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", 32'(in_ready), 1);
    @(negedge clk);

    // Basic vector with per-cycle operand checks.
    applyStimulus(32'h7654_3210, 32'h0123_4567, 1'b1);
    checkOutput("basic_result_56", 32'(result), 56);
    consumeCheck();

    // All-maximum elements.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("max_result_1800", 32'(result), 1800);
    consumeCheck();

    // Back-pressure while a new pair is being offered.
    out_ready = 1'b0;
    ra = $urandom;
    rb = $urandom;
    applyStimulus(ra, rb, 1'b0);
    ra = $urandom;
    rb = $urandom;
    A = ra;
    B = rb;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_out_valid_c%0d", c), 32'(out_valid), 1);
      checkOutput($sformatf("bp_result_c%0d", c), 32'(result), heldResult);
      checkOutput($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", 32'(in_ready), 1);
    checkOutput("bp_release_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    finishRun(ra, rb, 1'b1);
    consumeCheck();

    // Synchronous abort in RUN cycle 4.
    A = $urandom;
    B = $urandom;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clear_busy", 32'(busy), 0);
    checkOutput("clear_in_ready", 32'(in_ready), 1);
    checkOutput("clear_opA", 32'(mul_multiplier), 0);
    checkOutput("clear_result_held", 32'(result), heldResult);
    repeat (10) @(negedge clk);
    checkOutput("clear_out_valid_never", 32'(out_valid), 0);
    ra = $urandom;
    rb = $urandom;
    applyStimulus(ra, rb, 1'b1);
    consumeCheck();

    // Asynchronous reset mid-RUN.
    A = $urandom;
    B = $urandom;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_in_ready", 32'(in_ready), 0);
    checkOutput("arst_result", 32'(result), 0);
    checkOutput("arst_opA", 32'(mul_multiplier), 0);
    heldResult = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ra = $urandom;
    rb = $urandom;
    applyStimulus(ra, rb, 1'b0);
    consumeCheck();

    // Random vectors, back to back.
    for (int v = 0; v < 8; v++) begin
      ra = $urandom;
      rb = $urandom;
      applyStimulus(ra, rb, v[0]);
      consumeCheck();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
